// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and default baud divisor.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // 100 MHz system clock at 115200 baud.
    localparam int UART_CLKS_PER_BIT_DEFAULT = 868;
    localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte handshake and serial-side signals between the transmit mux and the UART serializer.
interface uart_byte_tx_if;
    import uart_pkg::*;

    // Handshake: the master raises RequestToSend with DataIn stable and holds both until it
    // sees the one-cycle DataLoaded pulse; DataIn was captured on the edge before that pulse.
    logic                      RequestToSend;
    logic [UART_DATA_BITS-1:0] DataIn;
    logic                      DataLoaded;
    logic                      Tx;
    logic                      Busy;
    uart_state_e               State;

    modport master (
        output RequestToSend, DataIn,
        input  DataLoaded, Tx, Busy, State
    );

    modport slave (
        input  RequestToSend, DataIn,
        output DataLoaded, Tx, Busy, State
    );

endinterface

// File: rtl/uart_baud_counter.sv
// Restartable bit-period counter: BitDone marks the last clock of each CLKS_PER_BIT-cycle bit.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Restart,
    input  logic Enable,
    output logic BitDone
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_baud_counter: CLKS_PER_BIT must be >= 2");
    end

    logic [CW-1:0] cnt_q, cnt_d;

    assign BitDone = Enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (Restart) begin
            cnt_d = '0;
        end else if (Enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// UART 8N1/8N2 byte serializer, LSB first, with zero-gap back-to-back frames.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int STOP_BITS    = 1
) (
    input  logic           Clk,
    input  logic           Reset,
    uart_byte_tx_if.slave  tx_if
);

    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_byte_tx: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_byte_tx: STOP_BITS must be 1 or 2");
    end

    uart_state_e                state_q, state_d;
    logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
    logic [2:0]                 bit_cnt_q, bit_cnt_d;
    logic                       stop_cnt_q, stop_cnt_d;
    logic                       tx_q, tx_d;
    logic                       loaded_q, loaded_d;
    logic                       bit_done;
    logic                       final_stop;
    logic                       capture;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .Clk     (Clk),
        .Reset   (Reset),
        .Restart (capture),
        .Enable  (state_q != IDLE),
        .BitDone (bit_done)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        final_stop = (state_q == STOP) && bit_done && (stop_cnt_q == STOP_LAST);
        capture    = tx_if.RequestToSend && ((state_q == IDLE) || final_stop);

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = STOP;
                        tx_d       = 1'b1;
                        bit_cnt_d  = 3'd0;
                        stop_cnt_d = 1'b0;
                    end else begin
                        // Next bit is read from position 1 before the shift lands.
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d    = IDLE;
                        stop_cnt_d = 1'b0;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A capture overrides the IDLE return on the final stop cycle.
        if (capture) begin
            shift_d    = tx_if.DataIn;
            state_d    = START;
            tx_d       = 1'b0;
            bit_cnt_d  = 3'd0;
            stop_cnt_d = 1'b0;
        end
        loaded_d = capture;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            loaded_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            loaded_q   <= loaded_d;
        end
    end

    assign tx_if.Tx         = tx_q;
    assign tx_if.DataLoaded = loaded_q;
    assign tx_if.Busy       = (state_q != IDLE);
    assign tx_if.State      = state_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: frame-offset reference model checked every cycle plus directed frame checks.
module tb_uart_byte_tx;

    localparam int C  = 4;
    localparam int L0 = 10 * C;
    localparam int L1 = 11 * C;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_byte_tx_if if0 ();
    uart_byte_tx_if if1 ();

    logic       rts_v [2];
    logic [7:0] din_v [2];

    assign if0.RequestToSend = rts_v[0];
    assign if0.DataIn        = din_v[0];
    assign if1.RequestToSend = rts_v[1];
    assign if1.DataIn        = din_v[1];

    uart_byte_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut0 (
        .Clk (clk), .Reset (rst_n), .tx_if (if0)
    );
    uart_byte_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut1 (
        .Clk (clk), .Reset (rst_n), .tx_if (if1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is described only by its byte and the cycle offset since Tx fell.
    bit         m_busy [2];
    int         m_k    [2];
    logic [7:0] m_b    [2];
    bit         m_dl   [2];

    function automatic logic exp_tx(input logic [7:0] b, input int k);
        int idx;
        idx = k / C;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    task automatic model_step(input int d, input logic tx, input logic busy, input logic dl,
                              input int len);
        bit fin;
        if (!rst_n) begin
            m_busy[d] = 0;
            m_dl[d]   = 0;
            m_k[d]    = 0;
        end
        check($sformatf("dut%0d_tx", d), tx, m_busy[d] ? exp_tx(m_b[d], m_k[d]) : 1'b1);
        check($sformatf("dut%0d_busy", d), busy, m_busy[d]);
        check($sformatf("dut%0d_dl", d), dl, m_dl[d]);
        if (rst_n) begin
            fin = m_busy[d] && (m_k[d] == len - 1);
            if ((!m_busy[d] || fin) && rts_v[d] === 1'b1) begin
                m_busy[d] = 1;
                m_k[d]    = 0;
                m_b[d]    = din_v[d];
                m_dl[d]   = 1;
            end else begin
                m_dl[d] = 0;
                if (m_busy[d]) begin
                    if (fin) m_busy[d] = 0;
                    else     m_k[d]++;
                end
            end
        end
    endtask

    // ---------------- monitor logs ----------------
    int   cyc = 0;
    int   dl_t0[$];
    logic tx_log0[$];
    logic tx_log1[$];
    int   busy_cnt0, busy_cnt1, busy_first0, busy_last0;
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        model_step(0, if0.Tx, if0.Busy, if0.DataLoaded, L0);
        model_step(1, if1.Tx, if1.Busy, if1.DataLoaded, L1);
        cyc++;
        if (if0.DataLoaded) dl_t0.push_back(cyc);
        if (if0.Busy) begin
            busy_cnt0++;
            if (busy_cnt0 == 1) busy_first0 = cyc;
            busy_last0 = cyc;
            tx_log0.push_back(if0.Tx);
        end
        if (if1.Busy) begin
            busy_cnt1++;
            tx_log1.push_back(if1.Tx);
        end
    end

    task automatic clear_logs();
        dl_t0.delete();
        tx_log0.delete();
        tx_log1.delete();
        busy_cnt0   = 0;
        busy_cnt1   = 0;
        busy_first0 = 0;
        busy_last0  = 0;
    endtask

    function automatic logic [7:0] decode0(input int f);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            if (f * L0 + (j + 1) * C + C / 2 < tx_log0.size())
                r[j] = tx_log0[f * L0 + (j + 1) * C + C / 2];
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    function automatic logic get_dl(input int d);
        return (d == 1) ? if1.DataLoaded : if0.DataLoaded;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 1) ? if1.Busy : if0.Busy;
    endfunction

    task automatic wait_dl(input int d, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (get_dl(d)) seen = 1;
        end
        check(name, seen, 1'b1);
    endtask

    task automatic wait_idle(input int d);
        bit idle;
        idle = 0;
        for (int i = 0; i < 400 && !idle; i++) begin
            @(posedge clk); #1;
            if (!get_busy(d)) idle = 1;
        end
        check($sformatf("dut%0d_idle_reached", d), idle, 1'b1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [7:0] b);
        @(posedge clk); #1;
        rts_v[d] = 1'b1;
        din_v[d] = b;
        wait_dl(d, $sformatf("dut%0d_send_dl", d));
        rts_v[d] = 1'b0;
    endtask

    task automatic rand_run(input int d, input int n);
        bit hold;
        hold = 0;
        for (int i = 0; i < n; i++) begin
            if (!hold) begin
                int gap;
                gap = $urandom_range(0, 50);
                repeat (gap) begin
                    @(posedge clk); #1;
                    din_v[d] = 8'($urandom);
                end
                @(posedge clk); #1;
            end
            rts_v[d] = 1'b1;
            din_v[d] = 8'($urandom);
            wait_dl(d, $sformatf("dut%0d_rand_dl", d));
            hold = 1'($urandom_range(0, 1));
            if (!hold) rts_v[d] = 1'b0;
            else begin
                @(posedge clk); #1;
            end
        end
        rts_v[d] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] bits;
        int         zeros, ones;
        rts_v[0] = 1'b0; rts_v[1] = 1'b0;
        din_v[0] = 8'h00; din_v[1] = 8'h00;
        clear_logs();

        // Reset held with inputs toggling
        repeat (5) begin
            @(posedge clk); #1;
            rts_v[0] = 1'($urandom); rts_v[1] = 1'($urandom);
            din_v[0] = 8'($urandom); din_v[1] = 8'($urandom);
            #1;
            check("rst_tx", if0.Tx, 1'b1);
            check("rst_busy", if0.Busy, 1'b0);
            check("rst_dl", if0.DataLoaded, 1'b0);
        end
        @(posedge clk); #1;
        rts_v[0] = 1'b0; rts_v[1] = 1'b0;
        rst_n = 1'b1;
        clear_logs();
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_busy_cycles", busy_cnt0, 0);
        check("post_rst_dl_pulses", dl_t0.size(), 0);

        // Single byte 0xA5
        clear_logs();
        send(0, 8'hA5);
        wait_idle(0);
        check("a5_dl_pulses", dl_t0.size(), 1);
        check("a5_busy_cycles", busy_cnt0, 40);
        bits = '0;
        for (int i = 0; i < 10; i++)
            if (i * C + 2 < tx_log0.size()) bits[i] = tx_log0[i * C + 2];
        check("a5_frame_bits", bits, 10'b1101001010);

        // Mux-style burst of 0xDEADBEEF
        clear_logs();
        exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
        exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
        @(posedge clk); #1;
        rts_v[0] = 1'b1;
        din_v[0] = exp_q[0];
        for (int i = 0; i < 4; i++) begin
            wait_dl(0, "burst_dl");
            if (i < 3) begin
                @(posedge clk); #1;
                din_v[0] = exp_q[i + 1];
            end
        end
        rts_v[0] = 1'b0;
        wait_idle(0);
        check("burst_dl_pulses", dl_t0.size(), 4);
        for (int i = 1; i < dl_t0.size(); i++)
            check("burst_dl_spacing", dl_t0[i] - dl_t0[i - 1], 40);
        check("burst_busy_cycles", busy_cnt0, 160);
        check("burst_contiguous", busy_last0 - busy_first0 + 1, 160);
        for (int f = 0; f < 4; f++) begin
            check($sformatf("burst_byte%0d", f), decode0(f), exp_q.pop_front());
        end

        // Request raised during data bit 3, held until acknowledged
        clear_logs();
        exp_q.push_back(8'h5A); exp_q.push_back(8'h33);
        send(0, 8'h5A);
        repeat (16) @(posedge clk);
        #1;
        rts_v[0] = 1'b1;
        din_v[0] = 8'h33;
        wait_dl(0, "midframe_dl");
        rts_v[0] = 1'b0;
        wait_idle(0);
        check("midframe_dl_pulses", dl_t0.size(), 2);
        if (dl_t0.size() == 2) check("midframe_start_spacing", dl_t0[1] - dl_t0[0], 40);
        check("midframe_busy_cycles", busy_cnt0, 80);
        check("midframe_byte0", decode0(0), exp_q.pop_front());
        check("midframe_byte1", decode0(1), exp_q.pop_front());

        // Reset during data bit 5 of 0x3C, then a clean frame
        send(0, 8'h3C);
        repeat (24) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", if0.Tx, 1'b1);
        check("async_rst_busy", if0.Busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        clear_logs();
        exp_q.push_back(8'h81);
        send(0, 8'h81);
        wait_idle(0);
        check("after_rst_dl_pulses", dl_t0.size(), 1);
        check("after_rst_busy_cycles", busy_cnt0, 40);
        check("after_rst_byte", decode0(0), exp_q.pop_front());

        // Two stop bits, byte 0x00
        clear_logs();
        send(1, 8'h00);
        wait_idle(1);
        check("stop2_busy_cycles", busy_cnt1, 44);
        zeros = 0; ones = 0;
        for (int i = 0; i < tx_log1.size(); i++) begin
            if (i < 36 && tx_log1[i] == 1'b0) zeros++;
            if (i >= 36 && tx_log1[i] == 1'b1) ones++;
        end
        check("stop2_low_cycles", zeros, 36);
        check("stop2_high_cycles", ones, 8);

        // Randomized traffic on both instances
        fork
            rand_run(0, 40);
            rand_run(1, 40);
        join
        wait_idle(0);
        wait_idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- UART transmit serializer sitting directly downstream of the 32-bit-to-byte transmit mux.
- Accepts one byte per request/acknowledge handshake (RequestToSend / DataLoaded) and drives the serial Tx line as 8N1 (or 8N2) frames, LSB first.
- Supports gap-free back-to-back frames, so a 4-byte FIFO word leaves the device as four contiguous frames.

Parameters:
- CLKS_PER_BIT, 868, Clk cycles per serial bit (100 MHz / 115200); legal range >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- Clk  input  1  system clock; all logic is rising-edge.
- Reset  input  1  asynchronous, active-low reset.
- RequestToSend  input  1  upstream has a valid byte on DataIn; held high until acknowledged.
- DataIn  input  8  byte to transmit; must be stable while RequestToSend is high.
- DataLoaded  output  1  one-cycle acknowledge pulse; DataIn has been captured.
- Tx  output  1  serial line, idle high, registered (glitch-free).
- Busy  output  1  high while any frame bit is being driven.

Behaviour:
- One clock: Clk. Reset is asynchronous and active-low (Reset low = reset).
- Reset values: Tx=1, DataLoaded=0, Busy=0, state=IDLE, all counters=0, shift register=0.
- Reset asserted mid-frame: Tx goes to 1 immediately (asynchronously); the frame is abandoned and never resumed.
- States:
  - IDLE: Tx=1, Busy=0.
  - START, DATA, STOP: Busy=1.
- Capture edge: a rising edge where (state==IDLE or final STOP cycle) and RequestToSend==1.
  - ShiftReg<=DataIn, state<=START, Tx<=0, BitCnt<=0, BaudCnt<=0.
  - DataLoaded<=1 for exactly the following cycle, then 0.
- Latency: Tx falls in the cycle after the capture edge (1-cycle latency from RequestToSend sampled high).
- No recapture outside IDLE or the final STOP cycle.
  - Upstream keeps RequestToSend high and updates DataIn in the cycle after DataLoaded; this must not cause a duplicate capture.
- Baud timing: BaudCnt counts 0..CLKS_PER_BIT-1; BitDone = (BaudCnt==CLKS_PER_BIT-1). Every bit lasts exactly CLKS_PER_BIT cycles.
- Transitions:
  - START on BitDone: DATA, Tx<=ShiftReg[0].
  - DATA on BitDone: shift right, BitCnt+1, Tx<=next bit. After bit 7 (BitCnt==7): STOP, Tx<=1.
  - STOP: lasts STOP_BITS*CLKS_PER_BIT cycles, tracked by StopCnt.
  - On the final STOP cycle: if RequestToSend, capture edge (back-to-back, zero idle cycles); else IDLE.
- Frame length: (9+STOP_BITS)*CLKS_PER_BIT cycles, from Tx falling to the next possible Tx falling.
- Widths: BaudCnt is $clog2(CLKS_PER_BIT) bits; BitCnt is 3 bits; StopCnt is 1 bit. No counter may wrap outside its defined range.
- Simultaneous events: RequestToSend rising during START, DATA or STOP (not final cycle) is ignored until the final STOP cycle. Reset has priority over everything.
- Parameter checks: elaboration-time error if CLKS_PER_BIT<2 or STOP_BITS is not in {1,2}.

Decomposition:
- Package uart_pkg:
  - state enum / localparams IDLE, START, DATA, STOP (2-bit encoding).
  - default CLKS_PER_BIT constant.
  - UART_DATA_BITS=8.
- Sub-module uart_baud_counter:
  - restartable counter with Restart and Enable inputs and a BitDone pulse output.
  - parameterized by CLKS_PER_BIT.
  - reused later by the receive path.

Test Plan:
(All at CLKS_PER_BIT=4 unless stated.)
- Reset held low 5 cycles, inputs toggling -> Tx=1, DataLoaded=0, Busy=0 throughout; no frame starts after release with RequestToSend=0.
- Single byte 0xA5, RequestToSend held until DataLoaded:
  - exactly one DataLoaded pulse, 1 cycle after the sample.
  - Tx shows 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each 4 cycles; Busy high 40 cycles.
- Mux-style burst of word 0xDEADBEEF (bytes 0xDE,0xAD,0xBE,0xEF; DataIn updated the cycle after each pulse):
  - exactly 4 DataLoaded pulses, 40 cycles apart.
  - 160 contiguous frame cycles, no idle gap; decoded bytes DE AD BE EF.
- RequestToSend toggled high mid-frame (DATA bit 3) then held -> no capture until the final STOP cycle; next Tx start begins exactly 40 cycles after the previous start.
- Reset pulled low during DATA bit 5 of 0x3C:
  - Tx=1 in the same cycle (asynchronously); Busy=0.
  - after release, a new request for 0x81 produces a clean full frame.
- STOP_BITS=2, byte 0x00 -> Tx low 36 cycles, then high 8 cycles; Busy high 44 cycles.
